// File: rtl/regfile_pkg.sv
// Shared types and sizing for the dual-operand register file.
// Sizes are fixed here. ADDR_W is derived from DEPTH and is not set on its own.
package regfile_pkg;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t ZERO_REG = addr_t'(0);

    // Response buffer occupancy.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // A write can land only on a real register. Register 0 always reads as zero.
    function automatic logic write_hits(input logic we, input addr_t wa);
        return we && (wa != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_storage.sv
// Register array for regfile_read_port.
// Contents: write decode, the hardwired-zero register 0, and two combinational
// read muxes. Reads return the contents from before the edge (read-first).
module regfile_storage
    import regfile_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [WIDTH-1:0]  wd_i,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    output logic [WIDTH-1:0]  rd1_o,
    output logic [WIDTH-1:0]  rd2_o
);

    // Entry 0 has no storage at all, so it can never hold anything but zero.
    word_t            regs_q [1:DEPTH-1];
    logic [DEPTH-1:0] wen;

    // One-hot write enable. Writes to register 0 decode to nothing.
    always_comb begin
        wen = '0;
        if (write_hits(we_i, wa_i)) begin
            wen[wa_i] = 1'b1;
        end
    end

    // Storage update. Reset wins over a write on the same edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wen[i]) begin
                    regs_q[i] <= wd_i;
                end
            end
        end
    end

    // Read mux for port 1. Address 0 falls through to the zero default.
    always_comb begin
        rd1_o = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ra1_i == addr_t'(i)) begin
                rd1_o = regs_q[i];
            end
        end
    end

    // Read mux for port 2. It works the same way as port 1.
    always_comb begin
        rd2_o = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ra2_i == addr_t'(i)) begin
                rd2_o = regs_q[i];
            end
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// Dual-operand register file with a valid/ready read request channel and a
// one-entry, back-pressurable registered response.
// Optional build macro REGFILE_BYPASS_EN: a write and an accept on the same edge
// to the same non-zero address return the new write data (write-first).
// Without the macro the accept returns the old contents (read-first).
//
// state      | meaning
// -----------+---------------------------------------------------------
// RSP_EMPTY  | no response held; rsp_valid=0, request always accepted
// RSP_FULL   | rd1/rd2 hold a snapshot; frozen until rsp_ready
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2
);

    rsp_state_e state_q, state_d;
    word_t      rd1_q, rd1_d;
    word_t      rd2_q, rd2_d;
    word_t      st_rd1, st_rd2;
    word_t      op1, op2;
    logic       accept;

    regfile_storage u_storage (
        .clk_i   (CLK),
        .reset_i (reset),
        .we_i    (we),
        .wa_i    (wa),
        .wd_i    (wd),
        .ra1_i   (rs1),
        .ra2_i   (rs2),
        .rd1_o   (st_rd1),
        .rd2_o   (st_rd2)
    );

`ifdef REGFILE_BYPASS_EN
    // Write-first. A same-edge write forwards straight into the snapshot.
    assign op1 = (write_hits(we, wa) && (wa == rs1)) ? wd : st_rd1;
    assign op2 = (write_hits(we, wa) && (wa == rs2)) ? wd : st_rd2;
`else
    // Read-first. The snapshot takes the contents from before the edge.
    assign op1 = st_rd1;
    assign op2 = st_rd2;
`endif

    // Handshake. req_ready depends only on the state and rsp_ready, never on the request.
    assign rsp_valid = (state_q == RSP_FULL);
    assign req_ready = (state_q == RSP_EMPTY) || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign rd1       = rd1_q;
    assign rd2       = rd2_q;

    // Next-state and snapshot load. The data registers load only on an accept,
    // so they hold their value while stalled and after the buffer drains.
    always_comb begin
        state_d = state_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        case (state_q)
            RSP_EMPTY: begin
                if (accept) begin
                    state_d = RSP_FULL;
                end
            end
            RSP_FULL: begin
                if (accept) begin
                    state_d = RSP_FULL;
                end else if (rsp_ready) begin
                    state_d = RSP_EMPTY;
                end
            end
            default: state_d = RSP_EMPTY;
        endcase
        if (accept) begin
            rd1_d = op1;
            rd2_d = op2;
        end
    end

    // Response buffer registers, with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= RSP_EMPTY;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Testbench for regfile_read_port. A behavioural model (an array of registers
// plus a one-slot response) is checked against the DUT after every clock edge.
// Directed steps carry literal expectations, followed by a randomized phase.
module tb_regfile_read_port;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [2:0]  wa = '0;
    logic [15:0] wd = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  rs1 = '0;
    logic [2:0]  rs2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rd1;
    logic [15:0] rd2;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_read_port dut (
        .CLK       (CLK),
        .reset     (reset),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rd1       (rd1),
        .rd2       (rd2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Model state: the register contents and the held response.
    logic [15:0] m_regs [8] = '{default: 16'h0};
    logic        m_valid = 1'b0;
    logic [15:0] m_rd1 = '0;
    logic [15:0] m_rd2 = '0;
    logic        m_acc;

    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return m_regs[a];
    endfunction

    // Model update on each edge, then compare against the DUT just after it.
    always @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
            m_valid = 1'b0;
            m_rd1   = 16'h0;
            m_rd2   = 16'h0;
        end else begin
            m_acc = req_valid && (!m_valid || rsp_ready);
            if (m_acc) begin
                m_rd1   = m_read(rs1);
                m_rd2   = m_read(rs2);
                m_valid = 1'b1;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
            if (we && wa != 3'd0) m_regs[wa] = wd;
        end
        #1;
        chk("model_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
        chk("model_rd1", {16'b0, rd1}, {16'b0, m_rd1});
        chk("model_rd2", {16'b0, rd2}, {16'b0, m_rd2});
        chk("model_req_ready", {31'b0, req_ready}, {31'b0, (!m_valid || rsp_ready)});
    end

    task automatic req(input logic [2:0] a1, input logic [2:0] a2);
        req_valid = 1'b1;
        rs1 = a1;
        rs2 = a2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
    endtask

    initial begin
        // Reset, then a read of fresh registers.
        reset = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", {31'b0, req_ready}, 32'd1);
        chk("valid_after_reset", {31'b0, rsp_valid}, 32'd0);
        req(3'd3, 3'd5);
        @(negedge CLK);
        chk("reset_read_valid", {31'b0, rsp_valid}, 32'd1);
        chk("reset_read_rd1", {16'b0, rd1}, 32'h0);
        chk("reset_read_rd2", {16'b0, rd2}, 32'h0);

        // Write, then read.
        req_valid = 1'b0;
        wr(3'd3, 16'hA5A5);
        @(negedge CLK);
        wr(3'd5, 16'h1234);
        @(negedge CLK);
        we = 1'b0;
        req(3'd3, 3'd5);
        @(negedge CLK);
        chk("wr_rd_rd1", {16'b0, rd1}, 32'hA5A5);
        chk("wr_rd_rd2", {16'b0, rd2}, 32'h1234);

        // Register 0 stays zero.
        req_valid = 1'b0;
        wr(3'd0, 16'hFFFF);
        @(negedge CLK);
        we = 1'b0;
        req(3'd0, 3'd0);
        @(negedge CLK);
        chk("r0_rd1", {16'b0, rd1}, 32'h0);
        chk("r0_rd2", {16'b0, rd2}, 32'h0);

        // Back-pressure and snapshot.
        req(3'd3, 3'd5);
        @(negedge CLK);
        chk("bp_first_rd1", {16'b0, rd1}, 32'hA5A5);
        rsp_ready = 1'b0;
        wr(3'd3, 16'h0F0F);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            we = 1'b0;
            chk("bp_hold_rd1", {16'b0, rd1}, 32'hA5A5);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        chk("bp_after_rd1", {16'b0, rd1}, 32'h0F0F);

        // Same-edge write and accept to the same address.
        req_valid = 1'b0;
        wr(3'd3, 16'h1111);
        @(negedge CLK);
        wr(3'd3, 16'h2222);
        req(3'd3, 3'd3);
        @(negedge CLK);
        we = 1'b0;
`ifdef REGFILE_BYPASS_EN
        chk("hazard_rd1", {16'b0, rd1}, 32'h2222);
        chk("hazard_rd2", {16'b0, rd2}, 32'h2222);
`else
        chk("hazard_rd1", {16'b0, rd1}, 32'h1111);
        chk("hazard_rd2", {16'b0, rd2}, 32'h1111);
`endif

        // Full throughput: a request every cycle, so a response every cycle.
        for (int c = 0; c < 6; c++) begin
            req(3'(c + 1), 3'd5);
            @(negedge CLK);
            chk("tput_valid", {31'b0, rsp_valid}, 32'd1);
            chk("tput_ready", {31'b0, req_ready}, 32'd1);
        end

        // Reset while FULL, with a write pending on the same edge.
        req(3'd5, 3'd3);
        wr(3'd4, 16'hBEEF);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        we = 1'b0;
        req_valid = 1'b0;
        chk("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_mid_rd1", {16'b0, rd1}, 32'h0);
        chk("rst_mid_rd2", {16'b0, rd2}, 32'h0);
        for (int c = 0; c < 4; c++) begin
            req(3'(2 * c), 3'(2 * c + 1));
            @(negedge CLK);
            chk("rst_mid_regs_rd1", {16'b0, rd1}, 32'h0);
            chk("rst_mid_regs_rd2", {16'b0, rd2}, 32'h0);
        end

        // Randomized traffic, checked by the model on every edge.
        for (int c = 0; c < 3000; c++) begin
            we        = ($urandom_range(0, 2) == 0);
            wa        = 3'($urandom_range(0, 7));
            wd        = 16'($urandom);
            req_valid = ($urandom_range(0, 3) != 0);
            rs1       = 3'($urandom_range(0, 7));
            rs2       = ($urandom_range(0, 4) == 0) ? rs1 : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) rs1 = wa;
            rsp_ready = ($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 199) == 0);
            @(negedge CLK);
        end

        reset = 1'b0;
        we = 1'b0;
        req_valid = 1'b0;
        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
